// File: rtl/dmem_pkg.sv
// Shared types and helpers for the banked data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} dmem_state_e;

    // Bank holding byte k of an access starting at byte offset off; nb is a power of two.
    function automatic int unsigned lane_of(input int unsigned off,
                                            input int unsigned k,
                                            input int unsigned nb);
        return (off + k) & (nb - 1);
    endfunction

endpackage

// File: rtl/dmem_lane_rotator.sv
// Byte-lane rotation between the request/response data and the per-bank SRAM ports:
// store scatter with per-bank row/enable generation, load gather with extension.
module dmem_lane_rotator
    import dmem_pkg::*;
#(
    parameter int NB = 4,
    parameter int AW = 9
) (
    input  logic                   en,
    input  logic                   write,
    input  logic [31:0]            off,
    input  logic [1:0]             size,
    input  logic [8*NB-1:0]        wdata,
    output logic [NB-1:0]          cen,
    output logic [NB-1:0]          gwen,
    output logic [8*NB-1:0]        wen,
    output logic [NB*AW-1:0]       a,
    output logic [8*NB-1:0]        d,
    input  logic [8*NB-1:0]        q,
    input  logic [$clog2(NB)-1:0]  rd_lane,
    input  logic [1:0]             rd_size,
    input  logic                   rd_unsigned,
    output logic [8*NB-1:0]        rdata
);
    localparam int LW = $clog2(NB);

    int unsigned     wr_bytes;
    int unsigned     bank;
    int unsigned     rd_bytes;
    logic [8*NB-1:0] raw;
    logic            sign;

    // Each byte of the access goes to its own bank; a word-crossing access simply
    // gives the wrapped banks the next row, so it never needs a second beat.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        cen      = '1;
        gwen     = '1;
        wen      = '1;
        a        = '0;
        d        = '0;
        bank     = 0;
        wr_bytes = 32'd1 << size;
        if (en) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (k < wr_bytes) begin
                    bank               = lane_of(off, k, NB);
                    cen[bank]          = 1'b0;
                    gwen[bank]         = !write;
                    wen[8*bank +: 8]   = write ? 8'h00 : 8'hFF;
                    a[AW*bank +: AW]   = AW'((off + k) >> LW);
                    d[8*bank +: 8]     = wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        raw      = '0;
        sign     = 1'b0;
        rdata    = '0;
        rd_bytes = 32'd1 << rd_size;
        for (int unsigned k = 0; k < NB; k++) begin
            raw[8*k +: 8] = q[8*lane_of(32'(rd_lane), k, NB) +: 8];
        end
        for (int unsigned k = 0; k < NB; k++) begin
            if (k + 1 == rd_bytes) begin
                sign = !rd_unsigned && raw[8*k + 7];
            end
        end
        for (int unsigned k = 0; k < NB; k++) begin
            rdata[8*k +: 8] = (k < rd_bytes) ? raw[8*k +: 8] : {8{sign}};
        end
    end

endmodule

// File: rtl/dmem_banked_ctrl.sv
// Banked data-memory controller: one byte-wide SRAM macro per lane, any-alignment
// accesses in a single SRAM beat, valid/ready request and held response channels.
module dmem_banked_ctrl
    import dmem_pkg::*;
#(
    parameter int          NB    = 4,
    parameter int          DEPTH = 512,
    parameter logic [31:0] BASE  = 32'h0000_0000,
    localparam int         XLEN  = 8 * NB,
    localparam int         AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_rdata,
    output logic             rsp_error,
    output logic [NB-1:0]    CEN,
    output logic [NB-1:0]    GWEN,
    output logic [8*NB-1:0]  WEN,
    output logic [NB*AW-1:0] A,
    output logic [8*NB-1:0]  D,
    input  logic [8*NB-1:0]  Q
);
    localparam int          LW       = $clog2(NB);
    localparam logic [2:0]  MAX_SIZE = 3'(LW);
    localparam logic [32:0] WINDOW   = 33'(NB * DEPTH);

    dmem_state_e     state, state_nxt;
    logic            accept;
    logic            legal;
    logic [32:0]     off;
    logic [32:0]     span_end;
    logic [LW-1:0]   lane_r;
    mem_size_e       size_r;
    logic            unsigned_r;
    logic            write_r;
    logic [XLEN-1:0] load_data;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    // The extra top bit catches addresses below BASE and keeps the end-of-span sum from wrapping.
    assign off      = {1'b0, req_addr} - {1'b0, BASE};
    assign span_end = off + (33'd1 << req_size);
    assign legal    = ({1'b0, req_size} <= MAX_SIZE) && !off[32] && (span_end <= WINDOW);

    dmem_lane_rotator #(
        .NB (NB),
        .AW (AW)
    ) u_rotator (
        .en          (accept && legal && !rst),
        .write       (req_write),
        .off         (off[31:0]),
        .size        (req_size),
        .wdata       (req_wdata),
        .cen         (CEN),
        .gwen        (GWEN),
        .wen         (WEN),
        .a           (A),
        .d           (D),
        .q           (Q),
        .rd_lane     (lane_r),
        .rd_size     (size_r),
        .rd_unsigned (unsigned_r),
        .rdata       (load_data)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = legal ? ACCESS : RESP;
            ACCESS:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
            lane_r     <= '0;
            size_r     <= SZ_B;
            unsigned_r <= 1'b0;
            write_r    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lane_r     <= off[LW-1:0];
                size_r     <= mem_size_e'(req_size);
                unsigned_r <= req_unsigned;
                write_r    <= req_write;
                if (!legal) begin
                    rsp_error <= 1'b1;
                    rsp_rdata <= '0;
                end
            end
            // Q carries the rows addressed in the accept cycle; capture and hold for the consumer.
            if (state == ACCESS) begin
                rsp_rdata <= write_r ? '0 : load_data;
                rsp_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_banked_ctrl.sv
// Self-checking bench for dmem_banked_ctrl with NB=4, DEPTH=512, BASE=0: SRAM macro models,
// a flat byte-array reference model, and directed plus random traffic.
module tb_dmem_banked_ctrl;
    localparam int NB        = 4;
    localparam int DEPTH     = 512;
    localparam int AW        = 9;
    localparam int XLEN      = 32;
    localparam int MEM_BYTES = NB * DEPTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_error;
    logic [NB-1:0]     CEN;
    logic [NB-1:0]     GWEN;
    logic [8*NB-1:0]   WEN;
    logic [NB*AW-1:0]  A;
    logic [8*NB-1:0]   D;
    logic [8*NB-1:0]   Q = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_banked_ctrl #(.NB(NB), .DEPTH(DEPTH), .BASE(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .CEN          (CEN),
        .GWEN         (GWEN),
        .WEN          (WEN),
        .A            (A),
        .D            (D),
        .Q            (Q)
    );

    // Byte-wide single-port macros: bit-masked write, read data one cycle after CEN low.
    logic [7:0] sram [NB][DEPTH] = '{default: '0};
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!CEN[b]) begin
                if (!GWEN[b])
                    sram[b][A[AW*b +: AW]] <= (D[8*b +: 8] & ~WEN[8*b +: 8]) |
                                              (sram[b][A[AW*b +: AW]] & WEN[8*b +: 8]);
                Q[8*b +: 8] <= sram[b][A[AW*b +: AW]];
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: flat byte array plus a queue of expected responses.
    typedef struct {
        logic [31:0] rdata;
        logic        error;
        int          acc_cyc;
    } exp_t;

    logic [7:0] ref_mem [MEM_BYTES] = '{default: '0};
    exp_t       exp_q [$];
    bit         head_seen = 1'b0;

    task automatic model_accept();
        exp_t            e;
        int unsigned     n;
        longint unsigned p;
        longint unsigned v;
        bit              legal;
        logic [NB-1:0]   e_cen  = '1;
        logic [NB-1:0]   e_gwen = '1;
        logic [8*NB-1:0] e_wen  = '1;
        logic [NB*AW-1:0] e_a   = '0;
        logic [8*NB-1:0] e_d    = '0;
        n     = 32'd1 << req_size;
        legal = (req_size <= 2) && (longint'(req_addr) + n <= MEM_BYTES);
        v     = 0;
        if (legal) begin
            for (int unsigned k = 0; k < n; k++) begin
                p = longint'(req_addr) + k;
                e_cen[p % NB]            = 1'b0;
                e_gwen[p % NB]           = !req_write;
                e_wen[8*(p % NB) +: 8]   = req_write ? 8'h00 : 8'hFF;
                e_a[AW*(p % NB) +: AW]   = AW'(p / NB);
                e_d[8*(p % NB) +: 8]     = req_wdata[8*k +: 8];
                if (req_write) ref_mem[p] = req_wdata[8*k +: 8];
                else           v = v | (longint'(ref_mem[p]) << (8*k));
            end
            if (!req_write && !req_unsigned && v[8*n-1]) v = v | (~64'd0 << (8*n));
        end
        e.rdata   = (legal && !req_write) ? v[31:0] : 32'h0;
        e.error   = !legal;
        e.acc_cyc = cyc;
        check("accept_pins", 128'({CEN, GWEN, WEN, A, D}), 128'({e_cen, e_gwen, e_wen, e_a, e_d}));
        exp_q.push_back(e);
    endtask

    // Single compare process: SRAM pins every cycle, response channel whenever valid.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            head_seen = 1'b0;
            check("pins_idle_rst", 128'({CEN, GWEN, WEN, A, D}), 128'({{2*NB+8*NB{1'b1}}, {NB*AW+8*NB{1'b0}}}));
        end else begin
            if (req_valid && req_ready) model_accept();
            else check("pins_idle", 128'({CEN, GWEN, WEN, A, D}), 128'({{2*NB+8*NB{1'b1}}, {NB*AW+8*NB{1'b0}}}));
            if (rsp_valid) begin
                check("ready_while_busy", 128'(req_ready), 128'(0));
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 128'(1), 128'(0));
                end else begin
                    if (!head_seen) begin
                        check("latency", 128'(cyc - exp_q[0].acc_cyc), 128'(exp_q[0].error ? 1 : 2));
                        head_seen = 1'b1;
                    end
                    check("rsp_rdata", 128'(rsp_rdata), 128'(exp_q[0].rdata));
                    check("rsp_error", 128'(rsp_error), 128'(exp_q[0].error));
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
        end
    end

    logic [NB-1:0]    acc_cen;
    logic [NB*AW-1:0] acc_a;
    logic [8*NB-1:0]  acc_d;
    int               acc_cyc_last;

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd);
        bit got = 1'b0;
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_size = sz; req_unsigned = uns; req_wdata = wd;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                acc_cen = CEN; acc_a = A; acc_d = D; acc_cyc_last = cyc;
            end
        end
        check("req_accepted", 128'(got), 128'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic er);
        bit got = 1'b0;
        rd = '0; er = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1'b1; rd = rsp_rdata; er = rsp_error; end
        end
        check("rsp_arrived", 128'(got), 128'(1));
        @(posedge clk); #1;
    endtask

    task automatic access(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        do_req(wr, addr, sz, uns, wd);
        wait_rsp(rd, er);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          prev_cyc;
        bit          seen;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", 128'({req_ready, rsp_valid, rsp_rdata, rsp_error}), 128'({1'b1, 1'b0, 32'h0, 1'b0}));
        @(posedge clk); #1;

        // 1. aligned word store/load
        do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'h1122_3344);
        check("t1_cen", 128'(acc_cen), 128'(4'b0000));
        check("t1_a", 128'(acc_a), 128'({9'd4, 9'd4, 9'd4, 9'd4}));
        wait_rsp(rd, er);
        check("t1_store_rsp", 128'({rd, er}), 128'({32'h0, 1'b0}));
        access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd, er);
        check("t1_lw", 128'(rd), 128'(32'h1122_3344));

        // 2. word-crossing store at 0x0E
        do_req(1'b1, 32'h0E, 2'd2, 1'b0, 32'hAABB_CCDD);
        check("t2_a", 128'(acc_a), 128'({9'd3, 9'd3, 9'd4, 9'd4}));
        check("t2_d", 128'(acc_d), 128'(32'hCCDD_AABB));
        wait_rsp(rd, er);
        access(1'b0, 32'h0E, 2'd2, 1'b0, 32'h0, rd, er);
        check("t2_lw", 128'(rd), 128'(32'hAABB_CCDD));
        access(1'b0, 32'h10, 2'd0, 1'b1, 32'h0, rd, er);
        check("t2_lbu", 128'(rd), 128'(32'h0000_00BB));

        // 3. byte store with sign/zero-extended loads, neighbours preserved
        access(1'b1, 32'h20, 2'd2, 1'b0, 32'h5566_7788, rd, er);
        do_req(1'b1, 32'h21, 2'd0, 1'b0, 32'h0000_0080);
        check("t3_cen", 128'(acc_cen), 128'(4'b1101));
        wait_rsp(rd, er);
        access(1'b0, 32'h21, 2'd0, 1'b0, 32'h0, rd, er);
        check("t3_lb", 128'(rd), 128'(32'hFFFF_FF80));
        access(1'b0, 32'h21, 2'd0, 1'b1, 32'h0, rd, er);
        check("t3_lbu", 128'(rd), 128'(32'h0000_0080));
        access(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, rd, er);
        check("t3_lw", 128'(rd), 128'(32'h5566_8088));

        // 4. range end and oversize
        do_req(1'b0, 32'h7FE, 2'd2, 1'b0, 32'h0);
        check("t4_err_cen", 128'(acc_cen), 128'(4'hF));
        wait_rsp(rd, er);
        check("t4_lw_err", 128'({rd, er}), 128'({32'h0, 1'b1}));
        access(1'b1, 32'h7FE, 2'd1, 1'b0, 32'h0000_BEEF, rd, er);
        check("t4_sh_ok", 128'(er), 128'(0));
        access(1'b0, 32'h7FE, 2'd1, 1'b0, 32'h0, rd, er);
        check("t4_lh", 128'({rd, er}), 128'({32'hFFFF_BEEF, 1'b0}));
        access(1'b0, 32'h7FE, 2'd1, 1'b1, 32'h0, rd, er);
        check("t4_lhu", 128'(rd), 128'(32'h0000_BEEF));
        access(1'b0, 32'h0, 2'd3, 1'b0, 32'h0, rd, er);
        check("t4_size_err", 128'({rd, er}), 128'({32'h0, 1'b1}));

        // 5. response back-pressure, then reset mid-access and reset-cycle store
        rsp_ready = 1'b0;
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        check("t5_valid_seen", 128'(seen), 128'(1));
        for (int i = 0; i < 5; i++) begin
            check("t5_hold", 128'({rsp_valid, req_ready, rsp_rdata, rsp_error}),
                  128'({1'b1, 1'b0, 32'h1122_AABB, 1'b0}));
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1;

        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_rst_idle", 128'({rsp_valid, req_ready}), 128'({1'b0, 1'b1}));
        end
        @(posedge clk); #1;

        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40;
        req_size = 2'd2; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, rd, er);
        check("t5_rst_store_dropped", 128'(rd), 128'(32'h0));

        // 6. back-to-back loads, then random legal traffic against the model
        prev_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 32'h0E + 32'(i), 2'(i % 3), 1'(i % 2), 32'h0);
            if (i > 0) check("t6_throughput", 128'(acc_cyc_last - prev_cyc), 128'(3));
            prev_cyc = acc_cyc_last;
        end
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  sz;
            logic [31:0] ad;
            sz = 2'($urandom_range(0, 2));
            ad = (i % 8 == 7) ? 32'($urandom_range(MEM_BYTES - 16, MEM_BYTES - (1 << sz)))
                              : 32'($urandom_range(0, 64 - (1 << sz)));
            do_req(1'($urandom_range(0, 1)), ad, sz, 1'($urandom_range(0, 1)), $urandom);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
